// File: rtl/btb_pkg.sv
// Shared types and constants for the branch-target LUT update controller.
package btb_pkg;

  localparam int PC_W      = 16;
  localparam int LUT_ROW_W = 2 * PC_W + 1;

  typedef logic [PC_W-1:0]      pc_t;
  typedef logic [LUT_ROW_W-1:0] lut_row_t;

  // RUN: normal operation, CLEAR: LUT clear strobe, WAIT: settle cycle after clear
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CLEAR = 2'd1,
    WAIT  = 2'd2
  } btb_state_t;

  // LUT row layout: {pc, offset, history}; the stored target is pc + offset
  function automatic lut_row_t pack_row(input pc_t pc, input pc_t offset, input logic hist);
    return {pc, offset, hist};
  endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Signal bundle between the EX stage / LUT and the update controller.
//
// Handshake semantics: res_valid is a one-sided valid with no ready; the
// controller samples every cycle in which res_valid=1 and never back-pressures
// EX (updates it cannot hold are counted in drop_cnt). On the LUT side,
// lut_stall acts as an inverted ready: an update is transferred to the LUT
// only in a cycle where a queued entry exists and lut_stall=0, and the write
// is then presented as a single-cycle lut_write_en strobe on the next cycle.
interface btb_update_ctrl_if #(
  parameter int PC_W   = btb_pkg::PC_W,
  parameter int DROP_W = 8
);
  logic              res_valid;
  logic [PC_W-1:0]   res_pc;
  logic              res_taken;
  logic [PC_W-1:0]   res_target;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              inval_req;
  logic              lut_stall;

  logic              flush;
  logic [PC_W-1:0]   redirect_pc;
  logic              lut_write_en;
  logic [2*PC_W:0]   lut_write_data;
  logic              lut_clr;
  logic              inval_busy;
  logic [DROP_W-1:0] drop_cnt;

  // Pipeline / LUT side: drives resolutions and stalls, observes the controller
  modport master (
    output res_valid, res_pc, res_taken, res_target, pred_taken, pred_target,
    output inval_req, lut_stall,
    input  flush, redirect_pc, lut_write_en, lut_write_data, lut_clr,
    input  inval_busy, drop_cnt
  );

  // Controller side
  modport slave (
    input  res_valid, res_pc, res_taken, res_target, pred_taken, pred_target,
    input  inval_req, lut_stall,
    output flush, redirect_pc, lut_write_en, lut_write_data, lut_clr,
    output inval_busy, drop_cnt
  );
endinterface

// File: rtl/btb_upd_fifo.sv
// Small in-order FIFO buffering LUT row updates ahead of the single write port.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = LUT_ROW_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Status from the extra pointer MSB: same index, different lap means full
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout    = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; flush empties the queue regardless of push/pop
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Branch-target LUT update controller: detects mispredicts and issues a
// registered flush/redirect, queues LUT row updates and drains them onto the
// single LUT write port, and sequences full LUT invalidates.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  btb_update_ctrl_if.slave  bus,
  output btb_state_t        fsm_state
);

  btb_state_t        state;
  logic              flush_q;
  pc_t               redirect_q;
  logic              wr_en_q;
  lut_row_t          wr_data_q;
  logic              clr_q;
  logic              busy_q;
  logic [DROP_W-1:0] drop_q;

  logic              mispredict;
  pc_t               redirect_next;
  pc_t               offset;
  lut_row_t          push_row;
  logic              push_req;
  logic              pop;
  logic              drop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  lut_row_t          head_row;

  // Mispredict detection, update formation and queue control
  always_comb begin
    mispredict    = bus.res_valid &
                    ((bus.pred_taken != bus.res_taken) |
                     (bus.res_taken & (bus.pred_target != bus.res_target)));
    redirect_next = bus.res_taken ? bus.res_target : bus.res_pc + pc_t'(1);
    // A not-taken update keeps the previously predicted offset in the row
    offset        = (bus.res_taken ? bus.res_target : bus.pred_target) - bus.res_pc;
    push_row      = pack_row(bus.res_pc, offset, bus.res_taken);
    // An invalidate accepted this cycle wins over any update
    push_req      = bus.res_valid & (bus.res_taken | bus.pred_taken) &
                    (state == RUN) & ~bus.inval_req;
    // No pop on the accept cycle so a write can never coincide with lut_clr
    pop           = ~fifo_empty & ~bus.lut_stall & (state == RUN) & ~bus.inval_req;
    drop          = push_req & fifo_full & ~pop;
    fifo_flush    = (state == CLEAR);
  end

  btb_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (LUT_ROW_W)
  ) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push_req),
    .pop   (pop),
    .flush (fifo_flush),
    .din   (push_row),
    .dout  (head_row),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Invalidate sequencer with registered clear strobe and busy flag
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= RUN;
      clr_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.inval_req) begin
            state  <= CLEAR;
            clr_q  <= 1'b1;
            busy_q <= 1'b1;
          end else begin
            clr_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        CLEAR: begin
          state  <= WAIT;
          clr_q  <= 1'b0;
          busy_q <= 1'b1;
        end
        WAIT: begin
          if (bus.inval_req) begin
            state  <= CLEAR;
            clr_q  <= 1'b1;
            busy_q <= 1'b1;
          end else begin
            state  <= RUN;
            clr_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          clr_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered flush/redirect and LUT write port, one cycle after the cause
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      flush_q    <= mispredict;
      redirect_q <= mispredict ? redirect_next : '0;
      wr_en_q    <= pop;
      if (pop) wr_data_q <= head_row;
    end
  end

  // Saturating count of updates lost to a full queue
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redirect_q;
  assign bus.lut_write_en   = wr_en_q;
  assign bus.lut_write_data = wr_data_q;
  assign bus.lut_clr        = clr_q;
  assign bus.inval_busy     = busy_q;
  assign bus.drop_cnt       = drop_q;
  assign fsm_state          = state;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: mispredict flush/redirect, LUT update
// queueing and ordering, drop counting, invalidate sequencing and reset.
module tb_btb_update_ctrl;
  import btb_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clr_n;
  btb_state_t fsm_state;

  always #5 clk = ~clk;

  btb_update_ctrl_if #(.PC_W(16), .DROP_W(8)) bus ();

  btb_update_ctrl #(.DEPTH(4), .DROP_W(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          passes = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                           input logic ptk, input logic [15:0] ptgt);
    bus.res_valid   = 1'b1;
    bus.res_pc      = pc;
    bus.res_taken   = tk;
    bus.res_target  = tgt;
    bus.pred_taken  = ptk;
    bus.pred_target = ptgt;
  endtask

  task automatic res_idle();
    bus.res_valid = 1'b0;
  endtask

  task automatic check_flush(input string tag, input logic exp_f, input logic [15:0] exp_pc);
    check({tag, "_flush"}, bus.flush, exp_f);
    if (exp_f) check({tag, "_redirect"}, bus.redirect_pc, exp_pc);
  endtask

  task automatic check_write(input string tag);
    logic [32:0] exp;
    check({tag, "_en"}, bus.lut_write_en, 1);
    check({tag, "_qsize"}, exp_q.size() != 0, 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check({tag, "_data"}, bus.lut_write_data, exp);
  endtask

  task automatic check_no_write(input string tag);
    check({tag, "_nowr"}, bus.lut_write_en, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] pc;
    clr_n           = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_pc      = '0;
    bus.res_taken   = 1'b0;
    bus.res_target  = '0;
    bus.pred_taken  = 1'b0;
    bus.pred_target = '0;
    bus.inval_req   = 1'b0;
    bus.lut_stall   = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_flush", bus.flush, 0);
    check("rst_redirect", bus.redirect_pc, 0);
    check("rst_wr_en", bus.lut_write_en, 0);
    check("rst_wr_data", bus.lut_write_data, 0);
    check("rst_clr", bus.lut_clr, 0);
    check("rst_busy", bus.inval_busy, 0);
    check("rst_drop", bus.drop_cnt, 0);
    check("rst_state", fsm_state, RUN);
    clr_n = 1'b1;
    tick();

    // Taken mispredict: redirect to target, row {0010,0030,1}
    drive_res(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
    exp_q.push_back({16'h0010, 16'h0030, 1'b1});
    tick();
    res_idle();
    check_flush("t2", 1, 16'h0040);
    check_no_write("t2_lat");
    tick();
    check_flush("t2_once", 0, 0);
    check_write("t2_wr");
    tick();
    check_no_write("t2_done");

    // Not-taken mispredict: redirect pc+1, row keeps predicted offset
    drive_res(16'h0020, 1'b0, 16'h0000, 1'b1, 16'h0028);
    exp_q.push_back({16'h0020, 16'h0008, 1'b0});
    tick();
    res_idle();
    check_flush("t3", 1, 16'h0021);
    tick();
    check_flush("t3_once", 0, 0);
    check_write("t3_wr");

    // Correct taken prediction: no flush, row still written
    drive_res(16'h0030, 1'b1, 16'h0034, 1'b1, 16'h0034);
    exp_q.push_back({16'h0030, 16'h0004, 1'b1});
    tick();
    res_idle();
    check_flush("t4a", 0, 0);
    tick();
    check_write("t4a_wr");
    // Correct not-taken with no prediction: nothing at all
    drive_res(16'h0050, 1'b0, 16'h0060, 1'b0, 16'h0070);
    tick();
    res_idle();
    check_flush("t4b", 0, 0);
    check_no_write("t4b_a");
    tick();
    check_no_write("t4b_b");

    // Stalled LUT: 6 pushes, 4 held, 2 dropped, then drained in order
    bus.lut_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc = 16'h0100 + 16'(i * 16);
      drive_res(pc, 1'b1, pc + 16'(4 + i), 1'b1, pc + 16'(4 + i));
      if (i < 4) exp_q.push_back({pc, 16'(4 + i), 1'b1});
      tick();
    end
    res_idle();
    check("t5_drop", bus.drop_cnt, 2);
    check_no_write("t5_stalled");
    bus.lut_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_write("t5_drain");
    end
    tick();
    check_no_write("t5_empty");

    // Full FIFO with push and pop in the same cycle: no drop
    bus.lut_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 16'h0200 + 16'(i * 16);
      drive_res(pc, 1'b1, pc + 16'h0008, 1'b1, pc + 16'h0008);
      exp_q.push_back({pc, 16'h0008, 1'b1});
      tick();
    end
    bus.lut_stall = 1'b0;
    drive_res(16'h0280, 1'b1, 16'h0288, 1'b1, 16'h0288);
    exp_q.push_back({16'h0280, 16'h0008, 1'b1});
    tick();
    res_idle();
    check_write("t5_pp");
    check("t5_pp_drop", bus.drop_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_write("t5_pp_drain");
    end
    tick();
    check_no_write("t5_pp_empty");

    // Invalidate with 3 queued entries: clear strobe, queue discarded
    bus.lut_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 16'h0500 + 16'(i * 16);
      drive_res(pc, 1'b1, pc + 16'h0002, 1'b1, pc + 16'h0002);
      tick();
    end
    res_idle();
    bus.lut_stall = 1'b0;
    bus.inval_req = 1'b1;
    tick();
    bus.inval_req = 1'b0;
    check("t6_clr", bus.lut_clr, 1);
    check("t6_busy1", bus.inval_busy, 1);
    check("t6_state_clear", fsm_state, CLEAR);
    check_no_write("t6_clr");
    // Mispredict during CLEAR: flushes, pushes nothing
    drive_res(16'h0300, 1'b1, 16'h0310, 1'b0, 16'h0000);
    tick();
    res_idle();
    check("t6_clr_once", bus.lut_clr, 0);
    check("t6_busy2", bus.inval_busy, 1);
    check("t6_state_wait", fsm_state, WAIT);
    check_flush("t6_mp", 1, 16'h0310);
    check_no_write("t6_wait");
    tick();
    check("t6_busy_off", bus.inval_busy, 0);
    check("t6_state_run", fsm_state, RUN);
    check_no_write("t6_run");
    tick();
    check_no_write("t6_run2");
    tick();
    check_no_write("t6_run3");

    // Invalidate and mispredict together in RUN: flush kept, update dropped
    bus.inval_req = 1'b1;
    drive_res(16'h0400, 1'b1, 16'h0420, 1'b0, 16'h0000);
    tick();
    bus.inval_req = 1'b0;
    res_idle();
    check_flush("t6b", 1, 16'h0420);
    check("t6b_clr", bus.lut_clr, 1);
    tick();
    tick();
    check("t6b_state_run", fsm_state, RUN);
    tick();
    check_no_write("t6b_a");
    tick();
    check_no_write("t6b_b");

    // inval_req held through WAIT re-enters CLEAR
    bus.inval_req = 1'b1;
    tick();
    check("t6c_clear1", fsm_state, CLEAR);
    tick();
    check("t6c_wait", fsm_state, WAIT);
    check("t6c_wait_clr", bus.lut_clr, 0);
    tick();
    check("t6c_clear2", fsm_state, CLEAR);
    check("t6c_clr2", bus.lut_clr, 1);
    check("t6c_busy", bus.inval_busy, 1);
    bus.inval_req = 1'b0;
    tick();
    tick();
    check("t6c_run", fsm_state, RUN);
    check("t6c_busy_off", bus.inval_busy, 0);

    // Wrap-around arithmetic
    drive_res(16'hFFF0, 1'b1, 16'h0010, 1'b0, 16'h0000);
    exp_q.push_back({16'hFFF0, 16'h0020, 1'b1});
    tick();
    res_idle();
    check_flush("t7a", 1, 16'h0010);
    tick();
    check_write("t7a_wr");
    drive_res(16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h0005);
    exp_q.push_back({16'hFFFF, 16'h0006, 1'b0});
    tick();
    res_idle();
    check_flush("t7b", 1, 16'h0000);
    tick();
    check_write("t7b_wr");

    // Asynchronous reset mid-clear with queued traffic
    bus.lut_stall = 1'b1;
    drive_res(16'h0600, 1'b1, 16'h0602, 1'b1, 16'h0602);
    tick();
    drive_res(16'h0610, 1'b1, 16'h0612, 1'b1, 16'h0612);
    tick();
    res_idle();
    bus.inval_req = 1'b1;
    tick();
    check("t1_pre_clr", bus.lut_clr, 1);
    #2;
    clr_n = 1'b0;
    #1;
    check("t1_async_clr", bus.lut_clr, 0);
    check("t1_async_state", fsm_state, RUN);
    check("t1_async_busy", bus.inval_busy, 0);
    check("t1_async_drop", bus.drop_cnt, 0);
    check("t1_async_flush", bus.flush, 0);
    check("t1_async_wr", bus.lut_write_en, 0);
    bus.inval_req = 1'b0;
    bus.lut_stall = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
    tick();
    check_no_write("t1_post_a");
    tick();
    check_no_write("t1_post_b");
    drive_res(16'h0700, 1'b1, 16'h0710, 1'b1, 16'h0710);
    exp_q.push_back({16'h0700, 16'h0010, 1'b1});
    tick();
    res_idle();
    check_no_write("t1_new_lat");
    tick();
    check_write("t1_new_wr");
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
